// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: {bout,d} = a - b - bin, captured when in_valid is high.
// Every bit slice is a 9-gate network of 2-input NANDs; no arithmetic operators in the datapath.
module full_subtractor #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    // Per-slice internal nets.
    logic [WIDTH-1:0] t1;    // nand(a,b)
    logic [WIDTH-1:0] t2;    // nand(a,t1)
    logic [WIDTH-1:0] n1;    // nand(b,t1) == ~(~a & b)
    logic [WIDTH-1:0] x;     // a ^ b
    logic [WIDTH-1:0] u1;    // nand(x,c)
    logic [WIDTH-1:0] u2;    // nand(x,u1)
    logic [WIDTH-1:0] n2;    // nand(c,u1) == ~(~x & c)
    logic [WIDTH-1:0] diff;  // x ^ c
    logic [WIDTH:0]   c;     // borrow chain, c[0] = bin

    assign c[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        // First XOR stage; its third gate doubles as the ~a&b borrow term.
        assign t1[i] = ~(a[i] & b[i]);
        assign t2[i] = ~(a[i] & t1[i]);
        assign n1[i] = ~(b[i] & t1[i]);
        assign x[i]  = ~(t2[i] & n1[i]);

        // Second XOR stage against the incoming borrow.
        assign u1[i]   = ~(x[i] & c[i]);
        assign u2[i]   = ~(x[i] & u1[i]);
        assign n2[i]   = ~(c[i] & u1[i]);
        assign diff[i] = ~(u2[i] & n2[i]);

        assign c[i+1] = ~(n1[i] & n2[i]);
    end

    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             out_valid_q, out_valid_d;

    // Operands are only sampled under in_valid, so junk on idle cycles never reaches d/bout.
    always_comb begin
        d_d         = d_q;
        bout_d      = bout_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            d_d    = diff;
            bout_d = c[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            bout_q      <= bout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign d         = d_q;
    assign bout      = bout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor at WIDTH 1, 4 and 8: arithmetic reference model checked every
// cycle, plus literal expectations for the hand-worked cases.
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       inv = 1'b0;
    logic       bin = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;

    logic       ov1, ov4, ov8;
    logic       d1;
    logic [3:0] d4;
    logic [7:0] d8;
    logic       bo1, bo4, bo8;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inv), .a(a1), .b(b1), .bin(bin),
        .out_valid(ov1), .d(d1), .bout(bo1)
    );
    full_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inv), .a(a4), .b(b4), .bin(bin),
        .out_valid(ov4), .d(d4), .bout(bo4)
    );
    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inv), .a(a8), .b(b8), .bin(bin),
        .out_valid(ov8), .d(d8), .bout(bo8)
    );

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction; borrow is the sign, difference is modulo 2^w.
    function automatic logic [8:0] ref_sub(input int w, input int av, input int bv, input int cv);
        int dif;
        int m;
        dif = av - bv - cv;
        m = 1 << w;
        return {(dif < 0) ? 1'b1 : 1'b0, 8'((dif + m) % m)};
    endfunction

    logic       m_ov;
    logic [8:0] m1, m4, m8;  // {bout, d zero-extended}

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov <= 1'b0;
            m1   <= '0;
            m4   <= '0;
            m8   <= '0;
        end else begin
            m_ov <= inv;
            if (inv) begin
                m1 <= ref_sub(1, int'(a1), int'(b1), int'(bin));
                m4 <= ref_sub(4, int'(a4), int'(b4), int'(bin));
                m8 <= ref_sub(8, int'(a8), int'(b8), int'(bin));
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ov1", 9'(ov1), 9'(m_ov));
            chk("ov4", 9'(ov4), 9'(m_ov));
            chk("ov8", 9'(ov8), 9'(m_ov));
            chk("w1", {bo1, 7'b0, d1}, {m1[8], 7'b0, m1[0]});
            chk("w4", {bo4, 4'b0, d4}, {m4[8], 4'b0, m4[3:0]});
            chk("w8", {bo8, d8}, m8);
        end
    end

    // Inputs change 2 time units after the rising edge, well clear of both edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check4(input string name, input logic [3:0] ed, input logic eb, input logic ev);
        chk({name, "_d"}, 9'(d4), 9'(ed));
        chk({name, "_bout"}, 9'(bo4), 9'(eb));
        chk({name, "_ov"}, 9'(ov4), 9'(ev));
    endtask

    task automatic apply4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        a4  = av;
        b4  = bv;
        bin = cv;
        inv = 1'b1;
        tick();
    endtask

    logic [1:0] w1_tab [8];  // {d,bout} for {a,b,bin} = 0..7

    initial begin
        w1_tab = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

        #1 rst_n = 1'b0;
        started = 1'b1;
        #1;
        check4("reset", 4'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v   = 3'(i);
            a1  = v[2];
            b1  = v[1];
            bin = v[0];
            inv = 1'b1;
            tick();
            chk($sformatf("w1_tab%0d", i), {7'b0, d1, bo1}, {7'b0, w1_tab[i]});
        end

        apply4(4'd3, 4'd5, 1'b0);
        check4("3m5", 4'hE, 1'b1, 1'b1);
        apply4(4'd9, 4'd4, 1'b1);
        check4("9m4m1", 4'h4, 1'b0, 1'b1);
        apply4(4'd0, 4'd0, 1'b1);
        check4("ripple_all", 4'hF, 1'b1, 1'b1);
        apply4(4'hF, 4'hF, 1'b0);
        check4("f_m_f", 4'h0, 1'b0, 1'b1);

        // Hold: idle cycles with changing operands must leave the result alone.
        apply4(4'd7, 4'd2, 1'b0);
        check4("cap7m2", 4'h5, 1'b0, 1'b1);
        inv = 1'b0;
        a4  = 4'd0;
        b4  = 4'd1;
        for (int i = 0; i < 3; i++) begin
            bin = 1'($urandom);
            a8  = 8'($urandom);
            tick();
            check4($sformatf("hold%0d", i), 4'h5, 1'b0, 1'b0);
        end

        // Asynchronous reset between edges.
        apply4(4'd3, 4'd5, 1'b0);
        check4("pre_rst", 4'hE, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check4("mid_rst", 4'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        inv   = 1'b0;
        tick();
        check4("post_rst", 4'h0, 1'b0, 1'b0);

        // Random traffic on all widths, with occasional idle cycles.
        for (int i = 0; i < 1000; i++) begin
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            bin = 1'($urandom);
            inv = ($urandom_range(0, 3) != 0);
            tick();
        end
        inv = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
